// File: rtl/operand_fetch.sv
// operand_fetch: decode stage with register-file read, scoreboard RAW interlock and one output pipeline register.
module operand_fetch #(
    parameter bit R0_ZERO = 1'b1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    output logic [2:0]         rA_Addr,
    output logic [2:0]         rB_Addr,
    input  logic [63:0]        rA_Data,
    input  logic [63:0]        rB_Data,
    input  logic               wb_valid,
    input  logic [2:0]         wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_op,
    output logic               out_we,
    output logic [2:0]         out_rd,
    output logic [63:0]        out_imm,
    output logic [63:0]        out_a,
    output logic [63:0]        out_b,
    output logic [7:0]         busy,
    output logic [STALL_W-1:0] stall_cnt
);
    logic [3:0]         op;
    logic               we;
    logic [2:0]         rd, rs1, rs2;
    logic [17:0]        imm;
    logic               hz_a, hz_b, hz_d, hazard, accept;
    logic [7:0]         set_m, clr_m;
    logic               out_valid_d, out_valid_q;
    logic [3:0]         out_op_d, out_op_q;
    logic               out_we_d, out_we_q;
    logic [2:0]         out_rd_d, out_rd_q;
    logic [63:0]        out_imm_d, out_imm_q;
    logic [63:0]        out_a_d, out_a_q;
    logic [63:0]        out_b_d, out_b_q;
    logic [7:0]         busy_d, busy_q;
    logic [STALL_W-1:0] stall_d, stall_q;

    assign {op, we, rd, rs1, rs2, imm} = in_instr;
    assign rA_Addr = rs1;
    assign rB_Addr = rs2;

    // Hazard looks only at registered busy, so a writeback never bypasses into this cycle.
    always_comb begin
        hz_a   = busy_q[rs1] && !(R0_ZERO && rs1 == 3'd0);
        hz_b   = busy_q[rs2] && !(R0_ZERO && rs2 == 3'd0);
        hz_d   = we && busy_q[rd] && !(R0_ZERO && rd == 3'd0);
        hazard = in_valid && (hz_a || hz_b || hz_d);
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept = in_valid && in_ready;
    end

    always_comb begin
        set_m = (accept && we && !(R0_ZERO && rd == 3'd0)) ? 8'd1 << rd : 8'd0;
        clr_m = wb_valid ? 8'd1 << wb_addr : 8'd0;
        busy_d = (busy_q & ~clr_m) | set_m;
        stall_d = (hazard && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_op_d  = accept ? op : out_op_q;
        out_we_d  = accept ? we : out_we_q;
        out_rd_d  = accept ? rd : out_rd_q;
        out_imm_d = accept ? {{46{imm[17]}}, imm} : out_imm_q;
        out_a_d   = accept ? rA_Data : out_a_q;
        out_b_d   = accept ? rB_Data : out_b_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_we_q    <= 1'b0;
            out_rd_q    <= '0;
            out_imm_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            busy_q      <= '0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_we_q    <= out_we_d;
            out_rd_q    <= out_rd_d;
            out_imm_q   <= out_imm_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            busy_q      <= busy_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_we    = out_we_q;
    assign out_rd    = out_rd_q;
    assign out_imm   = out_imm_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign busy      = busy_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_operand_fetch;
    localparam int SW = 6;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [31:0]   in_instr = '0;
    logic [2:0]    rA_Addr, rB_Addr;
    logic [63:0]   rA_Data, rB_Data;
    logic          wb_valid = 1'b0;
    logic [2:0]    wb_addr = '0;
    logic          out_valid, out_ready = 1'b1, out_we;
    logic [3:0]    out_op;
    logic [2:0]    out_rd;
    logic [63:0]   out_imm, out_a, out_b;
    logic [7:0]    busy;
    logic [SW-1:0] stall_cnt;
    logic [63:0]   rf [8];
    int            n_run = 0, n_fail = 0;

    // Reference state: one pending bundle, a set of busy registers, a saturating stall tally.
    bit            m_valid, m_we;
    bit [3:0]      m_op;
    bit [2:0]      m_rd;
    bit [63:0]     m_imm, m_a, m_b;
    bit            m_busy [8];
    int            m_stall;

    assign rA_Data = rf[rA_Addr];
    assign rB_Data = rf[rB_Addr];

    always #5 clk = ~clk;

    operand_fetch #(.R0_ZERO(1'b1), .STALL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rA_Addr(rA_Addr), .rB_Addr(rB_Addr), .rA_Data(rA_Data), .rB_Data(rB_Data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_we(out_we), .out_rd(out_rd), .out_imm(out_imm),
        .out_a(out_a), .out_b(out_b), .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit reg_busy(input int r);
        return r != 0 && m_busy[r];
    endfunction

    function automatic bit m_hazard();
        int rd_i = int'(in_instr[26:24]);
        int s1 = int'(in_instr[23:21]);
        int s2 = int'(in_instr[20:18]);
        return in_valid && (reg_busy(s1) || reg_busy(s2) || (in_instr[27] && reg_busy(rd_i)));
    endfunction

    function automatic bit [7:0] m_busy_byte();
        bit [7:0] b = 0;
        for (int r = 0; r < 8; r++) if (m_busy[r]) b += 8'(1 << r);
        return b;
    endfunction

    task automatic m_clear();
        m_valid = 0; m_we = 0; m_op = 0; m_rd = 0; m_imm = 0; m_a = 0; m_b = 0; m_stall = 0;
        for (int r = 0; r < 8; r++) m_busy[r] = 0;
    endtask

    task automatic check_outs(input string pfx);
        check({pfx, "_valid"}, out_valid, m_valid);
        check({pfx, "_op"}, out_op, m_op);
        check({pfx, "_we"}, out_we, m_we);
        check({pfx, "_rd"}, out_rd, m_rd);
        check({pfx, "_imm"}, out_imm, m_imm);
        check({pfx, "_a"}, out_a, m_a);
        check({pfx, "_b"}, out_b, m_b);
        check({pfx, "_busy"}, busy, m_busy_byte());
        check({pfx, "_stall"}, stall_cnt, 64'(m_stall));
    endtask

    // Drive one cycle's inputs (we are just after a rising edge), check mid-cycle, then advance the model at the edge.
    task automatic step(input bit iv, input logic [31:0] ins, input bit ordy, input bit wbv, input logic [2:0] wba);
        bit hz, rdy, acc;
        in_valid = iv; in_instr = ins; out_ready = ordy; wb_valid = wbv; wb_addr = wba;
        @(negedge clk);
        hz = m_hazard();
        rdy = (!m_valid || ordy) && !hz;
        acc = iv && rdy;
        check_outs("cyc");
        check("in_ready", in_ready, rdy);
        check("rA_Addr", rA_Addr, ins[23:21]);
        check("rB_Addr", rB_Addr, ins[20:18]);
        @(posedge clk);
        if (hz && m_stall < (1 << SW) - 1) m_stall++;
        if (wbv) m_busy[wba] = 0;
        if (acc && ins[27] && ins[26:24] != 0) m_busy[ins[26:24]] = 1;
        if (acc) begin
            m_valid = 1; m_op = ins[31:28]; m_we = ins[27]; m_rd = ins[26:24];
            m_imm = 64'($signed(ins[17:0]));
            m_a = rf[ins[23:21]]; m_b = rf[ins[20:18]];
        end else if (ordy) m_valid = 0;
        #1;
    endtask

    // Pull reset low between edges and confirm everything clears without waiting for a clock.
    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1 check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_a", out_a, 0);
        check("rst_imm", out_imm, 0);
        m_clear();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic logic [31:0] mk(input int op, we, rd, s1, s2, imm);
        return {4'(op), 1'(we), 3'(rd), 3'(s1), 3'(s2), 18'(imm)};
    endfunction

    initial begin
        for (int r = 0; r < 8; r++) rf[r] = {$urandom, $urandom};
        rf[1] = 64'h11; rf[2] = 64'h22;
        m_clear();
        repeat (2) @(posedge clk);
        #1 check_outs("reset");
        rst = 1'b1;
        // basic fetch with negative immediate
        step(1, mk(2, 1, 3, 1, 2, 'h3FFFF), 1, 0, 0);
        check("basic_a", out_a, 64'h11);
        check("basic_b", out_b, 64'h22);
        check("basic_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("basic_busy", busy, 8'h08);
        // RAW on r3: writeback in the 4th stalled cycle, accept in the 5th
        for (int k = 0; k < 4; k++) step(1, mk(5, 0, 0, 3, 0, 5), 1, k == 3, 3);
        check("raw_stall", stall_cnt, 4);
        check("raw_busy", busy, 0);
        step(1, mk(5, 0, 0, 3, 0, 5), 1, 0, 0);
        check("raw_acc_valid", out_valid, 1);
        check("raw_acc_op", out_op, 5);
        // back-pressure holds without counting stalls
        for (int k = 0; k < 3; k++) step(1, mk(7, 0, 0, 1, 1, 9), 0, 0, 0);
        check("bp_op", out_op, 5);
        check("bp_stall", stall_cnt, 4);
        step(1, mk(7, 0, 0, 1, 1, 9), 1, 0, 0);
        check("bp_next_op", out_op, 7);
        // r0 is never tracked
        step(1, mk(1, 1, 0, 0, 0, 0), 1, 0, 0);
        check("r0_busy", busy, 0);
        step(1, mk(1, 0, 0, 0, 0, 0), 1, 0, 0);
        check("r0_acc", out_op, 1);
        // set and clear together
        step(1, mk(3, 1, 5, 1, 1, 0), 1, 0, 0);
        check("sc_pre", busy, 8'h20);
        step(1, mk(4, 1, 6, 1, 1, 0), 1, 1, 5);
        check("sc_busy", busy, 8'h40);
        step(1, mk(4, 1, 2, 1, 1, 0), 0, 0, 0);
        pulse_reset();
        step(1, mk(6, 0, 0, 1, 2, 1), 1, 0, 0);
        check("post_rst_acc", out_valid, 1);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) rf[$urandom_range(7)] = {$urandom, $urandom};
            if (i == 750) pulse_reset();
            step($urandom_range(3) != 0, $urandom, $urandom_range(3) != 0,
                 $urandom_range(2) == 0, 3'($urandom_range(7)));
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
